// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate-generation stage: decodes the format and the extended immediate
// on the input side, buffers up to two entries (output + skid), and counts illegal instructions.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    entry_t dec;
    entry_t out_q;
    entry_t skid_q;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   accept;

    // NOTE: every field gets a default before the case, so no path leaves a latch or an X.
    always_comb begin
        dec.instr   = instr;
        dec.imm     = '0;
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
        if (instr[1:0] == 2'b11) begin
            dec.illegal = 1'b0;
            case (instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                    dec.fmt = FMT_I;
                    // Shifts carry a zero-extended shamt; funct7 bits are not part of the immediate.
                    if (instr[6:0] == 7'b0010011 && instr[13:12] == 2'b01)
                        dec.imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
                    else
                        dec.imm = XLEN'($signed(instr[31:20]));
                end
                7'b0100011: begin
                    dec.fmt = FMT_S;
                    dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
                end
                7'b1100011: begin
                    dec.fmt = FMT_B;
                    dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                end
                7'b0110111, 7'b0010111: begin
                    dec.fmt = FMT_U;
                    dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
                end
                7'b1101111: begin
                    dec.fmt = FMT_J;
                    dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                end
                7'b0110011, 7'b0111011, 7'b0001111: begin
                    dec.fmt = FMT_R;
                end
                default: begin
                    dec.fmt     = FMT_ILL;
                    dec.illegal = 1'b1;
                end
            endcase
        end
    end

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;

    // NOTE: the data registers are reset as well, because out_* must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            illegal_cnt  <= '0;
        end else begin
            if (accept && dec.illegal && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + CNT_W'(1);

            if (flush) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (!out_valid_q || out_ready) begin
                // A held skid entry always moves first; in_ready is low then, so nothing new arrives.
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_q       <= dec;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule
